aes0_ct_buffer: RTL and testbench



---
 rtl/aes0_pkg.sv | 14 +
 rtl/aes0_ct_buffer.sv | 136 +++++++++++++
 tb/tb_aes0_ct_buffer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/aes0_pkg.sv
// Shared aes0 definitions: result/word widths, word index type and the
// register offsets of the result FIFO as seen by software.
package aes0_pkg;

   localparam int AES_CT_W   = 128;
   localparam int AES_WORD_W = 32;

   typedef logic [1:0] aes_word_idx_t;

   localparam logic [7:0] CT_FIFO_DATA   = 8'h40;
   localparam logic [7:0] CT_FIFO_STATUS = 8'h44;
   localparam logic [7:0] CT_FIFO_CLR    = 8'h48;

endpackage

// File: rtl/aes0_ct_buffer.sv
// Result FIFO behind the AES-192 core: captures each rising edge of out_valid
// and lets software drain results one word at a time; blind in debug mode.
module aes0_ct_buffer
   import aes0_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int CT_WIDTH = AES_CT_W,
   parameter int WORD_W   = AES_WORD_W
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       debug_mode_i,
   input  logic [CT_WIDTH-1:0]        ct_i,
   input  logic                       ct_valid_i,
   input  logic                       clr_i,
   input  logic                       pop_i,
   output logic [WORD_W-1:0]          rdata_o,
   output logic [1:0]                 word_idx_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       overflow_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CT_WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]       wr_ptr_r;
   logic [PW-1:0]       rd_ptr_r;
   logic [CW-1:0]       count_r;
   aes_word_idx_t       word_idx_r;
   logic                overflow_r;
   logic                ct_valid_q_r;

   logic                empty_s;
   logic                full_s;
   logic                push_s;
   logic                pop_ok_s;
   logic                free_s;
   logic                push_acc_s;
   logic                drop_s;
   logic [CT_WIDTH-1:0] head_s;
   logic [WORD_W-1:0]   rdata_s;

   assign empty_s    = (count_r == {CW{1'b0}});
   assign full_s     = (count_r == DEPTH_C);
   assign push_s     = ct_valid_i & ~ct_valid_q_r & ~debug_mode_i;
   assign pop_ok_s   = pop_i & ~empty_s & ~debug_mode_i;
   assign free_s     = pop_ok_s & (word_idx_r == 2'd3);
   // A full FIFO still accepts a result when the head entry is freed this cycle.
   assign push_acc_s = push_s & (~full_s | free_s);
   assign drop_s     = push_s & full_s & ~free_s;

   // Edge detector on the core's level-type valid; tracks even in debug or clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ct_valid_q_r <= 1'b0;
      end else begin
         ct_valid_q_r <= ct_valid_i;
      end
   end

   // Result storage; not reset because nothing reads it while empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !clr_i && push_acc_s) begin
         mem_r[wr_ptr_r] <= ct_i;
      end
   end

   // Pointer, word index, occupancy and sticky overflow state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         word_idx_r <= 2'd0;
         overflow_r <= 1'b0;
      end else if (clr_i) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         word_idx_r <= 2'd0;
         overflow_r <= 1'b0;
      end else if (debug_mode_i) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         word_idx_r <= 2'd0;
      end else begin
         if (push_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            word_idx_r <= word_idx_r + 2'd1;
         end
         if (free_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_acc_s, free_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Head word selection, forced to zero when empty or in debug mode.
   always_comb begin
      head_s  = mem_r[rd_ptr_r];
      rdata_s = {WORD_W{1'b0}};
      if (empty_s || debug_mode_i) begin
         rdata_s = {WORD_W{1'b0}};
      end else begin
         case (word_idx_r)
            2'd0:    rdata_s = head_s[WORD_W-1:0];
            2'd1:    rdata_s = head_s[2*WORD_W-1:WORD_W];
            2'd2:    rdata_s = head_s[3*WORD_W-1:2*WORD_W];
            2'd3:    rdata_s = head_s[4*WORD_W-1:3*WORD_W];
            default: rdata_s = {WORD_W{1'b0}};
         endcase
      end
   end

   assign rdata_o    = rdata_s;
   assign word_idx_o = word_idx_r;
   assign count_o    = count_r;
   assign empty_o    = empty_s;
   assign full_o     = full_s;
   assign overflow_o = overflow_r;

endmodule

// File: tb/tb_aes0_ct_buffer.sv
// Self-checking bench for aes0_ct_buffer: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_aes0_ct_buffer;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         debug = 1'b0;
   logic [127:0] ct = '0;
   logic         valid = 1'b0;
   logic         clr = 1'b0;
   logic         pop = 1'b0;
   logic [31:0]  rdata;
   logic [1:0]   word_idx;
   logic [2:0]   count;
   logic         empty;
   logic         full;
   logic         overflow;

   aes0_ct_buffer #(.DEPTH(DEPTH), .CT_WIDTH(128), .WORD_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .debug_mode_i(debug), .ct_i(ct), .ct_valid_i(valid),
      .clr_i(clr), .pop_i(pop), .rdata_o(rdata), .word_idx_o(word_idx), .count_o(count),
      .empty_o(empty), .full_o(full), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a queue of results plus the head word position.
   logic [127:0] q[$];
   int           m_idx = 0;
   bit           m_ovf = 0;
   bit           m_prev = 0;
   bit           started = 0;

   always @(posedge clk) begin
      bit do_push, do_pop;
      if (rst) begin
         q.delete(); m_idx = 0; m_ovf = 0; m_prev = 0; started = 1;
      end else begin
         do_push = valid && !m_prev && !debug;
         m_prev  = valid;
         if (clr) begin
            q.delete(); m_idx = 0; m_ovf = 0;
         end else if (debug) begin
            q.delete(); m_idx = 0;
         end else begin
            do_pop = pop && q.size() > 0;
            if (do_pop) begin
               if (m_idx == 3) begin
                  m_idx = 0;
                  void'(q.pop_front());
               end else m_idx++;
            end
            if (do_push) begin
               if (q.size() < DEPTH) q.push_back(ct);
               else m_ovf = 1;
            end
         end
      end
   end

   function automatic logic [31:0] model_rdata();
      logic [127:0] sh;
      if (q.size() == 0 || debug) return 32'h0;
      sh = q[0] >> (32 * m_idx);
      return sh[31:0];
   endfunction

   // Single compare process: every output against the model on each falling edge.
   always @(negedge clk) begin
      if (started) begin
         check("rdata", {96'h0, rdata}, {96'h0, model_rdata()});
         check("word_idx", {126'h0, word_idx}, 128'(m_idx));
         check("count", {125'h0, count}, 128'(q.size()));
         check("empty", {127'h0, empty}, {127'h0, q.size() == 0});
         check("full", {127'h0, full}, {127'h0, q.size() == DEPTH});
         check("overflow", {127'h0, overflow}, {127'h0, m_ovf});
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_one(input logic [127:0] v);
      ct = v; valid = 1'b1; cyc(); valid = 1'b0; cyc();
   endtask

   task automatic pop_one();
      pop = 1'b1; cyc(); pop = 1'b0;
   endtask

   logic [127:0] res [5];

   initial begin
      // 1: single capture from a held level, then word order
      rst = 1'b1; cyc(2); rst = 1'b0;
      check("rst_empty", {127'h0, empty}, 128'h1);
      check("rst_rdata", {96'h0, rdata}, 128'h0);
      ct = 128'h0F0E0D0C_0B0A0908_07060504_03020100; valid = 1'b1; cyc();
      check("t1_count", {125'h0, count}, 128'h1);
      check("t1_w0", {96'h0, rdata}, 128'h03020100);
      cyc(9);
      check("t1_count_hold", {125'h0, count}, 128'h1);
      valid = 1'b0;
      pop_one(); check("t1_w1", {96'h0, rdata}, 128'h07060504);
      pop_one(); check("t1_w2", {96'h0, rdata}, 128'h0B0A0908);
      pop_one(); check("t1_w3", {96'h0, rdata}, 128'h0F0E0D0C);
      pop_one(); check("t1_empty", {127'h0, empty}, 128'h1);

      // 2: five results into four entries
      for (int k = 0; k < 5; k++) begin
         res[k] = {$urandom, $urandom, $urandom, $urandom};
         push_one(res[k]);
      end
      check("t2_full", {127'h0, full}, 128'h1);
      check("t2_ovf", {127'h0, overflow}, 128'h1);
      for (int e = 0; e < 4; e++) begin
         for (int w = 0; w < 4; w++) begin
            logic [127:0] sh;
            sh = res[e] >> (32 * w);
            check("t2_drain", {96'h0, rdata}, {96'h0, sh[31:0]});
            pop_one();
         end
      end
      check("t2_empty", {127'h0, empty}, 128'h1);

      // 4: debug flush with two entries; overflow still set from above
      push_one(128'h11); push_one(128'h22);
      debug = 1'b1; ct = 128'h33; valid = 1'b1; cyc();
      check("t4_count", {125'h0, count}, 128'h0);
      check("t4_rdata", {96'h0, rdata}, 128'h0);
      check("t4_ovf", {127'h0, overflow}, 128'h1);
      debug = 1'b0; cyc();
      check("t4_nocap", {125'h0, count}, 128'h0);
      valid = 1'b0; cyc();

      // 5: pop on empty, then clear coinciding with a push edge
      pop_one();
      check("t5_pop_empty_idx", {126'h0, word_idx}, 128'h0);
      check("t5_pop_empty_cnt", {125'h0, count}, 128'h0);
      clr = 1'b1; ct = 128'h44; valid = 1'b1; cyc(); clr = 1'b0; valid = 1'b0;
      check("t5_clr_count", {125'h0, count}, 128'h0);
      check("t5_clr_ovf", {127'h0, overflow}, 128'h0);
      cyc();

      // 3: full FIFO, freeing pop coincides with a new edge
      for (int k = 0; k < 4; k++) push_one(128'(k + 100));
      pop_one(); pop_one(); pop_one();
      check("t3_idx3", {126'h0, word_idx}, 128'h3);
      pop = 1'b1; ct = 128'h5555; valid = 1'b1; cyc(); pop = 1'b0; valid = 1'b0;
      check("t3_count", {125'h0, count}, 128'h4);
      check("t3_ovf", {127'h0, overflow}, 128'h0);
      check("t3_head", {96'h0, rdata}, 128'd101);
      cyc();

      // 6: reset mid-drain
      pop_one(); pop_one();
      check("t6_idx2", {126'h0, word_idx}, 128'h2);
      rst = 1'b1; cyc(); rst = 1'b0;
      check("t6_count", {125'h0, count}, 128'h0);
      check("t6_idx", {126'h0, word_idx}, 128'h0);
      check("t6_empty", {127'h0, empty}, 128'h1);
      check("t6_rdata", {96'h0, rdata}, 128'h0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         clr   = ($urandom_range(0, 99) == 0);
         debug = ($urandom_range(0, 49) == 0);
         pop   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) valid = ~valid;
         ct = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      rst = 1'b0; clr = 1'b0; debug = 1'b0; pop = 1'b0; valid = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
